ysyx_22050550_div_unit: RTL and testbench

Iterative radix-2 restoring integer divider, the responder on the EXU's divide handshake. It accepts one 64-bit or 32-bit (word) signed or unsigned divide per request, iterates one quotient bit per cycle, and returns quotient and remainder with a one-cycle OutValid pulse. Results follow RISC-V M-extension semantics (DIV/DIVU/REM/REMU and the W variants), including divide-by-zero and signed overflow.

---
 rtl/ysyx_22050550_div_unit_if.sv | 28 ++
 rtl/ysyx_22050550_div_unit.sv | 198 +++++++++++++++++++
 tb/tb_ysyx_22050550_div_unit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050550_div_unit_if.sv
// Divide handshake bundle between the EXU (master) and divider (slave).
// Request: valid/flush/mode/operands; response: ready, result strobe, Q/R.
interface ysyx_22050550_div_unit_if;
  logic        io_Exu_DivValid;
  logic        io_Exu_Flush;
  logic        io_Exu_Divw;
  logic [1:0]  io_Exu_DivSigned;
  logic [63:0] io_Exu_Divdend;
  logic [63:0] io_Exu_Divisor;
  logic        io_Exu_DivReady;
  logic        io_Exu_OutValid;
  logic [63:0] io_Exu_Quotient;
  logic [63:0] io_Exu_Remainder;

  modport master (
    output io_Exu_DivValid, io_Exu_Flush, io_Exu_Divw,
    output io_Exu_DivSigned, io_Exu_Divdend, io_Exu_Divisor,
    input  io_Exu_DivReady, io_Exu_OutValid,
    input  io_Exu_Quotient, io_Exu_Remainder
  );

  modport slave (
    input  io_Exu_DivValid, io_Exu_Flush, io_Exu_Divw,
    input  io_Exu_DivSigned, io_Exu_Divdend, io_Exu_Divisor,
    output io_Exu_DivReady, io_Exu_OutValid,
    output io_Exu_Quotient, io_Exu_Remainder
  );
endinterface

// File: rtl/ysyx_22050550_div_unit.sv
// Radix-2 restoring divider (RV64M DIV/REM, W variants), one bit per cycle.
// Ports: clock, reset (sync, active-low), io = slave side of div handshake.
// Macro YSYX_22050550_DIV_ZERO_BYPASS_EN: div-by-zero/overflow skip BUSY.
module ysyx_22050550_div_unit (
  input  logic                          clock,
  input  logic                          reset,
  ysyx_22050550_div_unit_if.slave       io
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [63:0] rem_q, rem_d;
  logic [63:0] dvd_q, dvd_d;
  logic [63:0] dsr_q, dsr_d;
  logic [62:0] quo_q, quo_d;
  logic [63:0] a_q, a_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        divw_q, divw_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;
  logic [63:0] q_out_q, q_out_d;
  logic [63:0] r_out_q, r_out_d;

  logic [1:0]  sgn;
  logic [63:0] a_ext, b_ext, a_mag, b_mag;
  logic        sa, sb, in_dz, in_ovf;
  logic        accept, bypass, last;
  logic [64:0] sh, diff;
  logic        qbit;
  logic [63:0] rem_nx, quo_nx;
  logic [127:0] res;

  function automatic logic [127:0] fixup(
    input logic [63:0] q, input logic [63:0] r, input logic [63:0] a,
    input logic qn, input logic rn, input logic dz,
    input logic ovf, input logic w
  );
    logic [63:0] qs, rs;
    qs = qn ? -q : q;
    rs = rn ? -r : r;
    if (dz) begin
      qs = '1;
      rs = a;
    end else if (ovf) begin
      qs = a;
      rs = '0;
    end
    if (w) begin
      qs = {{32{qs[31]}}, qs[31:0]};
      rs = {{32{rs[31]}}, rs[31:0]};
    end
    return {qs, rs};
  endfunction

  // Operand preprocessing at accept: extend to 64, take magnitudes.
  always_comb begin
    sgn = io.io_Exu_DivSigned;
    if (io.io_Exu_Divw) begin
      a_ext = {{32{sgn[1] & io.io_Exu_Divdend[31]}},
               io.io_Exu_Divdend[31:0]};
      b_ext = {{32{sgn[0] & io.io_Exu_Divisor[31]}},
               io.io_Exu_Divisor[31:0]};
    end else begin
      a_ext = io.io_Exu_Divdend;
      b_ext = io.io_Exu_Divisor;
    end
    sa     = sgn[1] & a_ext[63];
    sb     = sgn[0] & b_ext[63];
    a_mag  = sa ? -a_ext : a_ext;
    b_mag  = sb ? -b_ext : b_ext;
    in_dz  = (b_ext == 64'd0);
    in_ovf = (sgn == 2'b11) && (&b_ext) &&
             (a_ext == {1'b1, 63'd0} ||
              (io.io_Exu_Divw && a_ext == {{33{1'b1}}, 31'd0}));
  end

  assign accept = (state_q == IDLE) && io.io_Exu_DivValid &&
                  !io.io_Exu_Flush;
  assign last   = (cnt_q == 7'd1);

`ifdef YSYX_22050550_DIV_ZERO_BYPASS_EN
  assign bypass = in_dz | in_ovf;
`else
  assign bypass = 1'b0;
`endif

  // One restoring step: shift in next dividend bit, trial subtract.
  assign sh     = {rem_q, dvd_q[63]};
  assign diff   = sh - {1'b0, dsr_q};
  assign qbit   = ~diff[64];
  assign rem_nx = qbit ? diff[63:0] : sh[63:0];
  assign quo_nx = {quo_q, qbit};

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = bypass ? DONE : BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (io.io_Exu_Flush) state_d = IDLE;
  end

  always_comb begin
    io.io_Exu_DivReady  = (state_q == IDLE);
    io.io_Exu_OutValid  = (state_q == DONE);
    io.io_Exu_Quotient  = q_out_q;
    io.io_Exu_Remainder = r_out_q;
  end

  always_comb begin
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    a_d     = a_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    divw_d  = divw_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    res     = '0;
    if (accept) begin
      cnt_d  = io.io_Exu_Divw ? 7'd32 : 7'd64;
      rem_d  = '0;
      // Word mode: park the 32-bit magnitude at the top so it shifts out first.
      dvd_d  = io.io_Exu_Divw ? {a_mag[31:0], 32'd0} : a_mag;
      dsr_d  = b_mag;
      quo_d  = '0;
      a_d    = a_ext;
      qneg_d = sa ^ sb;
      rneg_d = sa;
      divw_d = io.io_Exu_Divw;
      dz_d   = in_dz;
      ovf_d  = in_ovf;
      if (bypass) begin
        res = fixup('0, '0, a_ext, 1'b0, 1'b0, in_dz, in_ovf,
                    io.io_Exu_Divw);
        q_out_d = res[127:64];
        r_out_d = res[63:0];
      end
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - 7'd1;
      rem_d = rem_nx;
      dvd_d = {dvd_q[62:0], 1'b0};
      quo_d = quo_nx[62:0];
      if (last && !io.io_Exu_Flush) begin
        res = fixup(quo_nx, rem_nx, a_q, qneg_q, rneg_q, dz_q, ovf_q,
                    divw_q);
        q_out_d = res[127:64];
        r_out_d = res[63:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      a_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      divw_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      q_out_q <= '0;
      r_out_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      a_q     <= a_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      divw_q  <= divw_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
    end
  end
endmodule

// File: tb/tb_ysyx_22050550_div_unit.sv
// Bench for ysyx_22050550_div_unit: RISC-V M reference model + per-cycle
// compare of ready/strobe/held results, directed and random requests.
module tb_ysyx_22050550_div_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic chk = 1'b0;

  typedef struct {
    int          due;
    logic [63:0] q;
    logic [63:0] r;
  } exp_t;

  exp_t        pend[$];
  logic [63:0] exp_q = '0;
  logic [63:0] exp_r = '0;

  ysyx_22050550_div_unit_if bus();

  ysyx_22050550_div_unit dut (
    .clock (clk),
    .reset (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, req);
    end
  endtask

  // RISC-V M-extension results from plain arithmetic.
  task automatic ref_div(input logic w, input logic s,
                         input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r,
                         output logic sp);
    longint la, lb;
    int     wa, wb;
    logic [31:0] a32, b32, q32, r32;
    sp = 1'b0;
    if (!w) begin
      la = a;
      lb = b;
      if (b == 64'd0) begin
        q = '1; r = a; sp = 1'b1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = '0; sp = 1'b1;
      end else if (s) begin
        q = la / lb; r = la % lb;
      end else begin
        q = a / b; r = a % b;
      end
    end else begin
      a32 = a[31:0];
      b32 = b[31:0];
      wa = a32;
      wb = b32;
      if (b32 == 32'd0) begin
        q32 = '1; r32 = a32; sp = 1'b1;
      end else if (s && a32 == 32'h8000_0000 && b32 == '1) begin
        q32 = a32; r32 = '0; sp = 1'b1;
      end else if (s) begin
        q32 = wa / wb; r32 = wa % wb;
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end
  endtask

  // Compare process: every cycle, DUT outputs vs model.
  always @(negedge clk) begin
    logic ev, er;
    if (chk) begin
      ev = 1'b0;
      er = (pend.size() == 0);
      if (pend.size() != 0 && pend[0].due == cyc) begin
        ev = 1'b1;
        exp_q = pend[0].q;
        exp_r = pend[0].r;
        void'(pend.pop_front());
      end
      check("ready", {63'd0, bus.io_Exu_DivReady}, {63'd0, er});
      check("outvalid", {63'd0, bus.io_Exu_OutValid}, {63'd0, ev});
      check("quotient", bus.io_Exu_Quotient, exp_q);
      check("remainder", bus.io_Exu_Remainder, exp_r);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    bus.io_Exu_Divdend   = {$urandom(), $urandom()};
    bus.io_Exu_Divisor   = {$urandom(), $urandom()};
    bus.io_Exu_Divw      = 1'($urandom_range(0, 1));
    bus.io_Exu_DivSigned = 2'($urandom_range(0, 3));
  endtask

  task automatic drive(input logic w, input logic s,
                       input logic [63:0] a, input logic [63:0] b,
                       output exp_t e);
    logic [63:0] q, r;
    logic sp;
    int lat;
    bus.io_Exu_DivValid  = 1'b1;
    bus.io_Exu_Divw      = w;
    bus.io_Exu_DivSigned = s ? 2'b11 : 2'b00;
    bus.io_Exu_Divdend   = a;
    bus.io_Exu_Divisor   = b;
    ref_div(w, s, a, b, q, r, sp);
    lat = w ? 33 : 65;
`ifdef YSYX_22050550_DIV_ZERO_BYPASS_EN
    if (sp) lat = 1;
`endif
    e.due = cyc + lat;
    e.q = q;
    e.r = r;
  endtask

  task automatic issue(input logic w, input logic s,
                       input logic [63:0] a, input logic [63:0] b,
                       output int t);
    int n;
    exp_t e;
    n = 0;
    while (bus.io_Exu_DivReady !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    check("ready_wait", {63'd0, bus.io_Exu_DivReady}, 64'd1);
    t = cyc;
    drive(w, s, a, b, e);
    step();
    bus.io_Exu_DivValid = 1'b0;
    scramble();
    pend.push_back(e);
  endtask

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'hFFFF_FFFF_8000_0000;
      4:       return 64'(32'($urandom()));
      5:       return 64'($urandom_range(0, 20));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    logic [63:0] q, r;
    logic sp;
    int t, k, n;
    exp_t e;

    bus.io_Exu_DivValid = 1'b0;
    bus.io_Exu_Flush    = 1'b0;
    scramble();

    // Pin the reference model with hand-computed values.
    ref_div(0, 0, 64'd100, 64'd7, q, r, sp);
    check("pin_100_7_q", q, 64'd14);
    check("pin_100_7_r", r, 64'd2);
    ref_div(0, 1, -64'd7, 64'd2, q, r, sp);
    check("pin_m7_2_q", q, 64'hFFFF_FFFF_FFFF_FFFD);
    check("pin_m7_2_r", r, 64'hFFFF_FFFF_FFFF_FFFF);
    ref_div(1, 1, 64'h8000_0000, '1, q, r, sp);
    check("pin_wovf_q", q, 64'hFFFF_FFFF_8000_0000);
    check("pin_wovf_r", r, 64'd0);
    ref_div(1, 0, 64'hFFFF_FFFF, 64'd2, q, r, sp);
    check("pin_wu_q", q, 64'h0000_0000_7FFF_FFFF);
    check("pin_wu_r", r, 64'd1);
    ref_div(0, 0, 64'd5, 64'd0, q, r, sp);
    check("pin_dz_q", q, '1);
    check("pin_dz_r", r, 64'd5);

    // Reset; outputs must be zero and ready high from the first cycle.
    step();
    chk = 1'b1;
    step();
    rst_n = 1'b1;
    step();

    issue(0, 0, 64'd100, 64'd7, t);
    issue(0, 1, -64'd7, 64'd2, t);
    issue(0, 1, 64'd7, -64'd2, t);
    issue(1, 1, 64'h0000_0000_8000_0000, '1, t);
    issue(1, 0, 64'h0000_0000_FFFF_FFFF, 64'd2, t);
    issue(0, 0, 64'd5, 64'd0, t);
    issue(0, 1, 64'h8000_0000_0000_0000, '1, t);
    issue(1, 0, 64'h1234_5678_0000_0009, 64'hABCD_0000_0000_0000, t);

    // Flush at T+10: no result, ready again at T+11, outputs held.
    issue(0, 0, 64'd1000, 64'd3, t);
    repeat (9) step();
    bus.io_Exu_Flush = 1'b1;
    step();
    bus.io_Exu_Flush = 1'b0;
    pend.delete();
    repeat (3) step();

    // Flush together with a request in IDLE: not accepted.
    bus.io_Exu_DivValid = 1'b1;
    bus.io_Exu_Flush    = 1'b1;
    step();
    bus.io_Exu_DivValid = 1'b0;
    bus.io_Exu_Flush    = 1'b0;
    repeat (2) step();

    // Reset at T+20 discards the op; then 9/3.
    issue(0, 0, 64'd77, 64'd5, t);
    repeat (19) step();
    rst_n = 1'b0;
    step();
    pend.delete();
    exp_q = '0;
    exp_r = '0;
    rst_n = 1'b1;
    step();
    issue(0, 0, 64'd9, 64'd3, t);

    // DivValid held high across a result: re-accepted right after DONE.
    n = 0;
    while (bus.io_Exu_DivReady !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    drive(1, 0, 64'd1000, 64'd3, e);
    step();
    pend.push_back(e);
    repeat (33) step();
    drive(1, 0, 64'd1000, 64'd3, e);
    step();
    bus.io_Exu_DivValid = 1'b0;
    pend.push_back(e);

    // Random requests, occasionally flushed mid-flight.
    for (int i = 0; i < 120; i++) begin
      logic w, s;
      w = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      issue(w, s, rnd_op(), rnd_op(), t);
      if ($urandom_range(0, 9) == 0) begin
        k = $urandom_range(1, w ? 32 : 64);
        repeat (k - 1) step();
        bus.io_Exu_Flush = 1'b1;
        step();
        bus.io_Exu_Flush = 1'b0;
        pend.delete();
      end
    end

    n = 0;
    while (pend.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check("drain", 64'(pend.size()), 64'd0);
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
